// File: rtl/add_pkg.sv
// Shared definitions for the nibble-serial adder sequencer.
package add_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_add.sv
// Combinational 4-bit adder slice with carry-in; the only adder in the sequencer.
module nibble_add (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  assign {co, s} = {1'b0, x} + {1'b0, y} + {4'b0000, ci};

endmodule

// File: rtl/add_seq.sv
// Multi-cycle adder: adds two NIBBLES-nibble operands through one shared 4-bit slice,
// least-significant nibble first, publishing sum/cout on entry to DONE.
module add_seq
  import add_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [NIBBLE_W*NIBBLES-1:0]  a,
  input  logic [NIBBLE_W*NIBBLES-1:0]  b,
  output logic                         busy,
  output logic                         done,
  output logic [NIBBLE_W*NIBBLES-1:0]  sum,
  output logic                         cout,
  output state_t                       state
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  // Handshake: start is a level sampled only in IDLE; done is a one-cycle pulse
  // and sum/cout are valid from that pulse until the next completed operation.

  state_t               state_next;
  logic [W-1:0]         op_a;
  logic [W-1:0]         op_b;
  logic [W-1:0]         acc;
  logic [W-1:0]         acc_next;
  logic                 carry;
  logic [IDX_W-1:0]     idx;
  logic                 last;
  logic [NIBBLE_W-1:0]  slice_x;
  logic [NIBBLE_W-1:0]  slice_y;
  logic [NIBBLE_W-1:0]  slice_s;
  logic                 slice_co;

  assign last = (idx == IDX_W'(NIBBLES - 1));
  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_comb begin
    slice_x  = op_a[int'(idx)*NIBBLE_W +: NIBBLE_W];
    slice_y  = op_b[int'(idx)*NIBBLE_W +: NIBBLE_W];
    acc_next = acc;
    acc_next[int'(idx)*NIBBLE_W +: NIBBLE_W] = slice_s;
  end

  nibble_add u_slice (
    .x  (slice_x),
    .y  (slice_y),
    .ci (carry),
    .s  (slice_s),
    .co (slice_co)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last)  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The result registers load from acc_next so the final nibble lands in sum
  // on the same edge that enters DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a  <= '0;
      op_b  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_a  <= a;
            op_b  <= b;
            acc   <= '0;
            carry <= 1'b0;
            idx   <= '0;
          end
        end
        RUN: begin
          acc   <= acc_next;
          carry <= slice_co;
          if (last) begin
            idx  <= '0;
            sum  <= acc_next;
            cout <= slice_co;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_add_seq.sv
// Self-checking bench for add_seq: scoreboarded results plus timing, hold,
// reset and single-nibble checks.
module tb_add_seq;
  import add_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start;
  logic [15:0] a, b, sum;
  logic        busy, done, cout;
  state_t      state;

  logic        rst1, start1;
  logic [3:0]  a1, b1, sum1;
  logic        busy1, done1, cout1;
  state_t      state1;

  add_seq #(.NIBBLES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .state(state)
  );

  add_seq #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst(rst1), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .state(state1)
  );

  // ---------------- scoreboard ----------------
  int          n_pass   = 0;
  int          n_checks = 0;
  int          done_cnt = 0;
  logic [16:0] exp_q[$];
  logic [16:0] mon_e;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      check("done_has_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("result", 32'({cout, sum}), 32'(mon_e));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_op(input logic [15:0] x, input logic [15:0] y);
    int          lat;
    int          busy_n;
    logic [16:0] e;
    e = 17'(x) + 17'(y);
    @(negedge clk);
    a = x; b = y; start = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
    lat = 1;
    busy_n = 0;
    while (done !== 1'b1 && lat < 20) begin
      if (busy === 1'b1) busy_n++;
      @(negedge clk);
      lat++;
    end
    check("done_seen", 32'(done), 32'd1);
    check("latency", 32'(lat), 32'd5);
    check("busy_cycles", 32'(busy_n), 32'd4);
    @(negedge clk);
    check("done_fall", 32'(done), 32'd0);
    check("sum_hold", 32'({cout, sum}), 32'(e));
  endtask

  // ---------------- stimulus ----------------
  int cnt0;

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    rst1 = 1'b1; start1 = 1'b0; a1 = '0; b1 = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_state", 32'(state), 32'(IDLE));
    rst = 1'b0; rst1 = 1'b0;

    // reset wins over a simultaneous start
    @(negedge clk);
    rst = 1'b1; start = 1'b1; a = 16'h0005; b = 16'h0005;
    @(negedge clk);
    check("rst_over_start_state", 32'(state), 32'(IDLE));
    check("rst_over_start_busy", 32'(busy), 32'd0);
    rst = 1'b0; start = 1'b0;

    run_op(16'h0000, 16'h0001);
    run_op(16'hFFFF, 16'h0001);
    run_op(16'h8888, 16'h8888);
    run_op(16'h0F0F, 16'h00F1);

    // start pulsed during RUN is ignored
    cnt0 = done_cnt;
    @(negedge clk);
    a = 16'h0001; b = 16'h0002; start = 1'b1;
    exp_q.push_back(17'h00003);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 16'h1111; b = 16'h1111; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("single_done", 32'(done_cnt - cnt0), 32'd1);
    check("sum_held", 32'(sum), 32'h0003);
    repeat (3) @(negedge clk);
    check("sum_held_later", 32'(sum), 32'h0003);

    // reset in the middle of RUN
    @(negedge clk);
    a = 16'hFFFF; b = 16'h0001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("busy_before_rst", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_sum", 32'(sum), 32'd0);
    check("midrst_cout", 32'(cout), 32'd0);
    check("midrst_state", 32'(state), 32'(IDLE));
    repeat (6) @(negedge clk);
    check("midrst_no_done", 32'(done_cnt - cnt0), 32'd1);

    run_op(16'h1234, 16'h4321);
    for (int i = 0; i < 6; i++) run_op(16'($urandom), 16'($urandom));

    // single-nibble instance
    @(negedge clk);
    a1 = 4'h8; b1 = 4'h8; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    check("n1_busy", 32'(busy1), 32'd1);
    check("n1_no_done_yet", 32'(done1), 32'd0);
    @(negedge clk);
    check("n1_done", 32'(done1), 32'd1);
    check("n1_sum", 32'(sum1), 32'h0);
    check("n1_cout", 32'(cout1), 32'd1);
    @(negedge clk);
    check("n1_done_fall", 32'(done1), 32'd0);
    check("n1_state", 32'(state1), 32'(IDLE));
    a1 = 4'h3; b1 = 4'h4; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    @(negedge clk);
    check("n1_done2", 32'(done1), 32'd1);
    check("n1_result2", 32'({cout1, sum1}), 32'h07);

    // ---------------- final report ----------------
    repeat (2) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/add_seq.md
# add_seq

Multi-cycle adder sequencer. It adds two NIBBLES×4-bit operands by driving a single shared 4-bit adder slice once per cycle, least-significant nibble first, and carries between nibbles in a register. It sits between a start/done command interface and the team's 4-bit adder datapath, trading latency for minimal adder area on the FPGA.

## Interface
- `NIBBLES`, default 4: operand width in nibbles (W = 4·NIBBLES); legal range 1–16.
- `clk`  in  1: the single clock; all state changes on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: command strobe; sampled only in IDLE.
- `a`  in  W: operand A; latched when start is accepted.
- `b`  in  W: operand B; latched when start is accepted.
- `busy`  out  1: high while in RUN.
- `done`  out  1: single-cycle pulse, high in the DONE state.
- `sum`  out  W: registered result; holds the last completed sum.
- `cout`  out  1: registered carry-out of the most significant nibble; holds with `sum`.

## Operation
- State machine has three states:
  - IDLE: waits for start.
  - RUN: processes one nibble per cycle.
  - DONE: result publish, one cycle.
- IDLE with start=1 at an edge:
  - latch a and b into operand registers;
  - clear the carry register and the partial-sum accumulator;
  - set nibble index idx=0;
  - go to RUN.
- IDLE with start=0: stay in IDLE.
- Each RUN edge:
  - present a[idx], b[idx] and the carry register to the slice;
  - write the slice sum into acc[idx];
  - write the slice carry-out into the carry register;
  - increment idx.
- On the edge that processes idx = NIBBLES−1:
  - load `sum` with the completed accumulator, including that last nibble;
  - load `cout` with that edge's slice carry-out;
  - go to DONE.
- DONE: done=1 for exactly one cycle, then go unconditionally to IDLE.
- start is ignored in RUN and DONE. There is no queuing; the requester must re-issue start once back in IDLE.
- `sum`/`cout` change only on entry to DONE. Partial results are never visible on the outputs.
- Arithmetic is unsigned modulo 2^W, and `cout` is bit W of a+b. There is no overflow flag beyond `cout`.
- Operand inputs may change freely after the accepting edge, because the latched copies are used.
- rst=1 at any edge, including mid-RUN:
  - state goes to IDLE and idx to 0;
  - carry, accumulator, `sum` and `cout` are cleared to 0;
  - busy=0 and done=0;
  - the in-flight operation is discarded.
  - rst takes priority over a simultaneous start.

## Timing
- Reset values: busy=0, done=0, sum=0, cout=0, state IDLE.
- Start accepted at edge E0 → busy=1 from E0 through E_NIBBLES.
- `sum`/`cout` valid and done=1 after edge E_NIBBLES. done falls after E_NIBBLES+1.
- Latency from start to done is NIBBLES+1 edges. A back-to-back start can be accepted at E_NIBBLES+2, so minimum throughput is one operation per NIBBLES+2 cycles.
- NIBBLES=1: RUN lasts one cycle and done appears after E1.
- The slice is combinational between the operand/carry registers and the accumulator. The single-cycle path is 4 bits of ripple carry.

## Structure
- Package `add_pkg`:
  - localparam NIBBLE_W=4;
  - state enum {IDLE, RUN, DONE}.
- Sub-module `nibble_add`: combinational 4-bit adder with carry-in.
  - Ports: x[3:0], y[3:0], ci, s[3:0], co.
  - Exactly one instance, shared across all nibble steps.
- idx register width is clog2(NIBBLES), minimum 1 bit.

## Test plan
All scenarios use NIBBLES=4 unless stated otherwise.
- Simple add: a=0x0000, b=0x0001, start → done pulse 5 edges later, sum=0x0001, cout=0, busy high for 4 cycles.
- Full ripple: a=0xFFFF, b=0x0001 → sum=0x0000, cout=1.
- Carry on every nibble: a=0x8888, b=0x8888 → sum=0x1110, cout=1.
- Mixed carries: a=0x0F0F, b=0x00F1 → sum=0x1000, cout=0.
- Start while busy, held-result checks:
  - pulse start with a=0x1111, b=0x1111 during RUN of 0x0001+0x0002 → only one done, sum=0x0003;
  - sum holds 0x0003 until the next completed operation.
- Reset mid-operation and NIBBLES=1:
  - assert rst at E2 of 0xFFFF+0x0001 → next cycle busy=0, done=0, sum=0, cout=0, state IDLE;
  - a fresh start then completes normally;
  - with NIBBLES=1, 0x8+0x8 → sum=0x0, cout=1, done after E1.
